// File: rtl/sys_ctrl.sv
// Command sequencer: parses RX byte frames into register-file write/read strobes and returns read data to TX.
// Latency: WrEn 1 cycle after data byte; TX_D_VLD 4 cycles after read address byte. Holds in TX_SEND while TX_Busy.
module sys_ctrl #(
    parameter int              ADDR_W     = 4,
    parameter int              DATA_W     = 8,
    parameter logic [DATA_W-1:0] WR_CMD   = 8'hAA,
    parameter logic [DATA_W-1:0] RD_CMD   = 8'hBB,
    parameter int              RD_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RdData_valid,
    input  logic              TX_Busy,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              CTRL_BUSY,
    output logic              CMD_ERR
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, TX_SEND
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic [DATA_W-1:0] txdata_q, txdata_d;
    logic              wren_q, wren_d;
    logic              rden_q, rden_d;
    logic              txvld_q, txvld_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        txdata_d = txdata_q;
        txvld_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD)      state_d = WR_ADDR;
                    else if (RX_P_DATA == RD_CMD) state_d = RD_ADDR;
                    else                          err_d   = 1'b1;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wrdata_d = RX_P_DATA;
                    state_d  = WR_EXEC;
                end
            end
            WR_EXEC: state_d = IDLE;
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (RdData_valid) begin
                    txdata_d = RdData;
                    state_d  = TX_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Read data never came back: abandon the frame without transmitting.
                    if (cnt_d == CNT_W'(RD_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            TX_SEND: begin
                if (!TX_Busy) begin
                    txvld_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wren_d = (state_d == WR_EXEC);
        rden_d = (state_d == RD_REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            txdata_q <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txvld_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            txdata_q <= txdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txvld_q  <= txvld_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign WrEn      = wren_q;
    assign RdEn      = rden_q;
    assign Address   = addr_q;
    assign WrData    = wrdata_q;
    assign TX_P_DATA = txdata_q;
    assign TX_D_VLD  = txvld_q;
    assign CTRL_BUSY = busy_q;
    assign CMD_ERR   = err_q;
endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: frame-level model checked every cycle, plus directed literal checks.
module tb_sys_ctrl;
    logic       CLK, RST;
    logic [7:0] RX_P_DATA, RdData, WrData, TX_P_DATA;
    logic       RX_D_VLD, RdData_valid, TX_Busy;
    logic       WrEn, RdEn, TX_D_VLD, CTRL_BUSY, CMD_ERR;
    logic [3:0] Address;

    int checks = 0;
    int errors = 0;

    sys_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_valid(RdData_valid), .TX_Busy(TX_Busy),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CTRL_BUSY(CTRL_BUSY),
        .CMD_ERR(CMD_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: one-cycle read latency; rf_mute withholds read data.
    logic [7:0] mem [16];
    logic       rf_mute = 1'b0;
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    always @(posedge CLK) begin
        if (WrEn) mem[Address] <= WrData;
        RdData_valid <= RdEn && !rf_mute;
        RdData       <= mem[Address];
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: collects bytes of a frame, then walks the operation it implies.
    localparam int OP_NONE = 0, OP_WR = 1, OP_RDREQ = 2, OP_WAIT = 3, OP_TX = 4;
    logic [7:0] frame [$];
    int         op = OP_NONE;
    int         waitn = 0;
    logic       e_wren = 0, e_rden = 0, e_txv = 0, e_err = 0, e_busy = 0;
    logic [3:0] e_addr = 0;
    logic [7:0] e_wrd = 0, e_txd = 0;

    task automatic model_step();
        logic [7:0] b;
        e_wren = 0; e_rden = 0; e_txv = 0; e_err = 0;
        if (RST) begin
            frame.delete(); op = OP_NONE;
            e_addr = 0; e_wrd = 0; e_txd = 0;
        end else begin
            case (op)
                OP_NONE: if (RX_D_VLD) begin
                    frame.push_back(RX_P_DATA);
                    if (frame[0] != 8'hAA && frame[0] != 8'hBB) begin
                        e_err = 1; frame.delete();
                    end else if (frame.size() == 2) begin
                        b = frame[1];
                        e_addr = b[3:0];
                        if (frame[0] == 8'hBB) begin
                            e_rden = 1; op = OP_RDREQ; frame.delete();
                        end
                    end else if (frame.size() == 3) begin
                        e_wrd = frame[2]; e_wren = 1; op = OP_WR; frame.delete();
                    end
                end
                OP_WR:    op = OP_NONE;
                OP_RDREQ: begin op = OP_WAIT; waitn = 0; end
                OP_WAIT: begin
                    if (RdData_valid) begin
                        e_txd = RdData; op = OP_TX;
                    end else begin
                        waitn++;
                        if (waitn == 15) begin e_err = 1; op = OP_NONE; end
                    end
                end
                OP_TX: if (!TX_Busy) begin e_txv = 1; op = OP_NONE; end
                default: op = OP_NONE;
            endcase
        end
        e_busy = (op != OP_NONE) || (frame.size() != 0);
    endtask

    always @(posedge CLK) begin
        model_step();
        #1;
        chk("m_wren",  {7'b0, WrEn},      {7'b0, e_wren});
        chk("m_rden",  {7'b0, RdEn},      {7'b0, e_rden});
        chk("m_addr",  {4'b0, Address},   {4'b0, e_addr});
        chk("m_wrdata", WrData,           e_wrd);
        chk("m_txdata", TX_P_DATA,        e_txd);
        chk("m_txvld", {7'b0, TX_D_VLD},  {7'b0, e_txv});
        chk("m_busy",  {7'b0, CTRL_BUSY}, {7'b0, e_busy});
        chk("m_err",   {7'b0, CMD_ERR},   {7'b0, e_err});
    end

    // Caller must be at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
    endtask

    initial begin
        RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00; TX_Busy = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_wren", {7'b0, WrEn}, 8'h00);
        chk("rst_busy", {7'b0, CTRL_BUSY}, 8'h00);
        chk("rst_addr", {4'b0, Address}, 8'h00);
        RST = 1'b0;

        // Write AA,05,3C
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        chk("wr_en",    {7'b0, WrEn}, 8'h01);
        chk("wr_addr",  {4'b0, Address}, 8'h05);
        chk("wr_data",  WrData, 8'h3C);
        chk("wr_busy",  {7'b0, CTRL_BUSY}, 8'h01);
        @(negedge CLK);
        chk("wr_en_off", {7'b0, WrEn}, 8'h00);
        chk("wr_idle",  {7'b0, CTRL_BUSY}, 8'h00);

        // Read BB,05 back-to-back with the write, TX free
        send_byte(8'hBB); send_byte(8'h05);
        chk("rd_en",    {7'b0, RdEn}, 8'h01);
        @(negedge CLK);
        chk("rd_en_off", {7'b0, RdEn}, 8'h00);
        @(negedge CLK);
        chk("rd_tx_early", {7'b0, TX_D_VLD}, 8'h00);
        @(negedge CLK);
        chk("rd_tx_vld", {7'b0, TX_D_VLD}, 8'h01);
        chk("rd_tx_dat", TX_P_DATA, 8'h3C);
        @(negedge CLK);
        chk("rd_tx_off", {7'b0, TX_D_VLD}, 8'h00);

        // Read with TX busy for 20 cycles; a stray byte during the hold is dropped
        TX_Busy = 1'b1;
        send_byte(8'hBB); send_byte(8'h05);
        for (int i = 0; i < 20; i++) begin
            chk("hold_txv", {7'b0, TX_D_VLD}, 8'h00);
            if (i >= 2) chk("hold_txd", TX_P_DATA, 8'h3C);
            RX_P_DATA = 8'hAA; RX_D_VLD = (i == 5);
            @(negedge CLK);
        end
        RX_D_VLD = 1'b0;
        TX_Busy = 1'b0;
        @(negedge CLK);
        chk("hold_rel_vld", {7'b0, TX_D_VLD}, 8'h01);
        chk("hold_rel_dat", TX_P_DATA, 8'h3C);
        chk("hold_rel_busy", {7'b0, CTRL_BUSY}, 8'h00);
        @(negedge CLK);
        chk("hold_rel_off", {7'b0, TX_D_VLD}, 8'h00);

        // Unknown opcode, then a write with truncated address
        send_byte(8'h12);
        chk("unk_err",  {7'b0, CMD_ERR}, 8'h01);
        chk("unk_wren", {7'b0, WrEn}, 8'h00);
        chk("unk_rden", {7'b0, RdEn}, 8'h00);
        send_byte(8'hAA); send_byte(8'h1F); send_byte(8'hFF);
        chk("trunc_en",   {7'b0, WrEn}, 8'h01);
        chk("trunc_addr", {4'b0, Address}, 8'h0F);
        chk("trunc_data", WrData, 8'hFF);
        @(negedge CLK);

        // Read timeout
        rf_mute = 1'b1;
        send_byte(8'hBB); send_byte(8'h02);
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            chk("to_wait_err",  {7'b0, CMD_ERR}, 8'h00);
            chk("to_wait_busy", {7'b0, CTRL_BUSY}, 8'h01);
        end
        @(negedge CLK);
        chk("to_err",  {7'b0, CMD_ERR}, 8'h01);
        chk("to_busy", {7'b0, CTRL_BUSY}, 8'h00);
        chk("to_txv",  {7'b0, TX_D_VLD}, 8'h00);
        @(negedge CLK);
        chk("to_err_off", {7'b0, CMD_ERR}, 8'h00);
        rf_mute = 1'b0;

        // Reset mid-frame
        send_byte(8'hAA); send_byte(8'h07);
        RST = 1'b1;
        @(negedge CLK);
        chk("mrst_addr", {4'b0, Address}, 8'h00);
        chk("mrst_wrd",  WrData, 8'h00);
        chk("mrst_txd",  TX_P_DATA, 8'h00);
        chk("mrst_busy", {7'b0, CTRL_BUSY}, 8'h00);
        chk("mrst_err",  {7'b0, CMD_ERR}, 8'h00);
        RST = 1'b0;
        send_byte(8'h55);
        chk("mrst_55_err",  {7'b0, CMD_ERR}, 8'h01);
        chk("mrst_55_wren", {7'b0, WrEn}, 8'h00);
        @(negedge CLK);

        // Opcode values inside a frame are plain address/data
        send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hBB);
        chk("mid_en",   {7'b0, WrEn}, 8'h01);
        chk("mid_addr", {4'b0, Address}, 8'h0A);
        chk("mid_data", WrData, 8'hBB);
        repeat (5) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Command sequencer between the UART receiver/transmitter and the 16x8 register file. It parses framed byte commands from RX into single-cycle register-file write and read strobes. Read data is returned to the TX side with a one-cycle valid pulse, gated by TX busy. It is the only master of the register file's WrEn/RdEn/Address/WrData.

Parameters:
WR_CMD, 8'hAA, opcode byte for a register write (frame: WR_CMD, addr, data)
RD_CMD, 8'hBB, opcode byte for a register read (frame: RD_CMD, addr)
ADDR_W, 4, register-file address width
DATA_W, 8, data and byte width
RD_TIMEOUT, 15, maximum cycles to wait for RdData_valid after RdEn

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  reset, synchronous, active-high
RX_P_DATA  input  DATA_W  received byte
RX_D_VLD  input  1  one-cycle strobe; RX_P_DATA valid
RdData  input  DATA_W  register-file read data
RdData_valid  input  1  register-file read-data valid
TX_Busy  input  1  high while transmitter cannot accept a byte
WrEn  output  1  register-file write strobe
RdEn  output  1  register-file read strobe
Address  output  ADDR_W  register-file address
WrData  output  DATA_W  register-file write data
TX_P_DATA  output  DATA_W  byte to transmit
TX_D_VLD  output  1  one-cycle strobe to transmitter
CTRL_BUSY  output  1  high whenever state != IDLE
CMD_ERR  output  1  one-cycle pulse on unknown opcode or read timeout

Behaviour:
- Reset (RST=1 at CLK edge): state=IDLE; WrEn, RdEn, TX_D_VLD, CMD_ERR, CTRL_BUSY=0; Address, WrData, TX_P_DATA=0; timeout counter=0. A reset mid-frame aborts the frame; no strobe is emitted afterwards.
- All outputs are registered. WrEn and RdEn are never high in the same cycle.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, RD_WAIT, TX_SEND.
- IDLE:
  - RX_D_VLD with byte==WR_CMD -> WR_ADDR.
  - byte==RD_CMD -> RD_ADDR.
  - Any other byte -> CMD_ERR=1 for one cycle, stay IDLE.
  - RX_D_VLD=0 -> stay.
- WR_ADDR: on RX_D_VLD, latch Address=byte[ADDR_W-1:0] (upper bits ignored) -> WR_DATA.
- WR_DATA: on RX_D_VLD, latch WrData=byte -> WR_EXEC.
- WR_EXEC: WrEn=1 for exactly this one cycle -> IDLE. Write lands in the register file on the edge ending WR_EXEC.
- RD_ADDR: on RX_D_VLD, latch Address -> RD_REQ.
- RD_REQ: RdEn=1 for exactly one cycle; clear timeout counter -> RD_WAIT.
- RD_WAIT:
  - RdData_valid=1 -> capture TX_P_DATA=RdData -> TX_SEND.
  - Otherwise increment the counter. When the counter reaches RD_TIMEOUT: CMD_ERR pulse -> IDLE, no TX.
  - Nominal latency from RdEn to capture is 1 cycle.
- TX_SEND:
  - TX_Busy=0 -> TX_D_VLD=1 for one cycle -> IDLE.
  - TX_Busy=1 -> hold (no timeout); TX_P_DATA is stable throughout.
- RX_D_VLD arriving in WR_EXEC, RD_REQ, RD_WAIT or TX_SEND is dropped silently; the frame in progress is unaffected.
- Mid-frame bytes equal to WR_CMD/RD_CMD are treated as address/data, not opcodes.
- Back-to-back frames: the first byte of the next frame is accepted on the first IDLE cycle.
- End-to-end latency: the write strobe occurs 1 cycle after the data-byte strobe. A read (TX_Busy=0) gives TX_D_VLD 4 cycles after the address-byte strobe.

Test Plan:
- Write: RX bytes AA,05,3C -> one WrEn pulse with Address=5, WrData=3C the cycle after byte 3; CTRL_BUSY falls the next cycle.
- Read with a register-file model (reg5=3C), TX_Busy=0: RX BB,05 -> single RdEn cycle; TX_D_VLD one cycle, TX_P_DATA=3C, 4 cycles after the address strobe.
- Read with TX_Busy=1 for 20 cycles: TX_D_VLD only on the first cycle after TX_Busy falls; TX_P_DATA held at the read value throughout.
- Unknown opcode 0x12 -> CMD_ERR one cycle, no WrEn/RdEn. Then AA,1F,FF -> Address=F (truncated), WrData=FF.
- Read timeout: RdData_valid tied 0; RX BB,02 -> CMD_ERR pulse after RD_TIMEOUT cycles in RD_WAIT, no TX_D_VLD, back to IDLE.
- Reset mid-frame: RX AA,07 then RST=1 for one cycle, then byte 55 -> no WrEn; 55 is treated as an opcode and raises CMD_ERR; all outputs 0 during reset.
